// File: rtl/dmem_pkg.sv
// Shared constants and helpers for data_memory_pipe.
// Optional statistics counters are enabled with DMEM_STATS_EN.
package dmem_pkg;

   localparam int BYTE_W = 8;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;

   function automatic int off_w(input int data_w);
      return $clog2(data_w / BYTE_W);
   endfunction

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module dmem_rsp_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W = 33,
   localparam int CW = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         store[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/data_memory_pipe.sv
// Word RAM with valid/ready requests, byte-enable stores and in-order
// load responses; DMEM_STATS_EN adds saturating access counters.
module data_memory_pipe
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH = 1024,
   parameter int RD_LAT = 1,
   parameter int FIFO_D = RD_LAT + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   input  logic [DATA_W/BYTE_W-1:0] req_be,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0]              stat_loads,
   output logic [31:0]              stat_stores,
   output logic [31:0]              stat_errs
`endif
);

   localparam int BE_W  = DATA_W / BYTE_W;
   localparam int OFF_W = off_w(DATA_W);
   localparam int IDX_W = idx_w(DEPTH);
   localparam int CW    = cnt_w(FIFO_D);
   localparam logic [ADDR_W-1:0] OFF_MASK =
      ADDR_W'((64'd1 << OFF_W) - 64'd1);

   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] rdata;
   } rsp_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              live;
   logic              fire;
   logic              ld_fire;
   logic              st_fire;
   logic [1:0]        err_code;
   logic              err;
   logic [IDX_W-1:0]  idx;
   rsp_t              fire_rsp;
   rsp_t              push_rsp;
   rsp_t              head;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [CW-1:0]     fifo_cnt;
   logic [CW-1:0]     pipe_cnt;
   logic [CW-1:0]     outstanding;

   assign idx = req_addr[OFF_W +: IDX_W];

   always_comb begin
      err_code = ERR_NONE;
      if (|(req_addr & OFF_MASK))
         err_code = err_code | ERR_MISALIGN;
      if (|(req_addr >> (OFF_W + IDX_W)))
         err_code = err_code | ERR_RANGE;
   end

   assign err     = (err_code != ERR_NONE);
   assign fire    = req_valid & req_ready;
   assign ld_fire = fire & ~req_write;
   assign st_fire = fire & req_write & ~err;

   // Load data is sampled before the same edge's store could land.
   always_comb begin
      fire_rsp.err   = err;
      fire_rsp.rdata = err ? '0 : mem[idx];
   end

   always_ff @(posedge clk) begin
      if (st_fire) begin
         for (int i = 0; i < BE_W; i++) begin
            if (req_be[i])
               mem[idx][i*BYTE_W +: BYTE_W] <= req_wdata[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         live <= 1'b0;
      else
         live <= 1'b1;
   end

   // Stage 0 is the fire cycle itself; RD_LAT-1 registers follow.
   if (RD_LAT == 1) begin : g_direct
      assign push     = ld_fire;
      assign push_rsp = fire_rsp;
      assign pipe_cnt = '0;
   end else begin : g_pipe
      logic [RD_LAT-2:0] pv;
      rsp_t              pr [RD_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT - 1; i++)
               pr[i] <= '0;
         end else begin
            pv[0] <= ld_fire;
            pr[0] <= fire_rsp;
            for (int i = 1; i < RD_LAT - 1; i++) begin
               pv[i] <= pv[i-1];
               pr[i] <= pr[i-1];
            end
         end
      end

      always_comb begin
         pipe_cnt = '0;
         for (int i = 0; i < RD_LAT - 1; i++)
            pipe_cnt = pipe_cnt + CW'(pv[i]);
      end

      assign push     = pv[RD_LAT-2];
      assign push_rsp = pr[RD_LAT-2];
   end

   // Credits: every load in flight owns a FIFO slot it is sure to get.
   assign outstanding = pipe_cnt + fifo_cnt;
   assign req_ready   = live & ~full & (outstanding < CW'(FIFO_D));

   dmem_rsp_fifo #(
      .DEPTH (FIFO_D),
      .W     ($bits(rsp_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_rsp),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_cnt)
   );

   assign rsp_valid = ~empty;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_rdata = empty ? '0 : head.rdata;
   assign rsp_err   = ~empty & head.err;

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else begin
         if (ld_fire && stat_loads != '1)
            stat_loads <= stat_loads + 32'd1;
         if (st_fire && stat_stores != '1)
            stat_stores <= stat_stores + 32'd1;
         if (fire && err && stat_errs != '1)
            stat_errs <= stat_errs + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Randomised, model-checked bench for data_memory_pipe (RD_LAT=2).
// Counter checks are compiled in when DMEM_STATS_EN is defined.
module tb_data_memory_pipe;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 1024;
   localparam int RD_LAT = 2;
   localparam int FIFO_D = RD_LAT + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_STATS_EN
   logic [31:0] stat_loads;
   logic [31:0] stat_stores;
   logic [31:0] stat_errs;
`endif

   data_memory_pipe #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT),
      .FIFO_D (FIFO_D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_be      (req_be),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err)
`ifdef DMEM_STATS_EN
      ,
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_errs   (stat_errs)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] ref_mem [DEPTH];
   logic [32:0] exp_q [$];
   int m_loads;
   int m_stores;
   int m_errs;
   int checks;
   int errors;

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a / 4 >= DEPTH);
   endfunction

   // Reference model: apply one accepted request.
   task automatic accept();
      int w;
      w = int'((req_addr / 4) % DEPTH);
      if (addr_bad(req_addr)) begin
         m_errs++;
         if (!req_write) begin
            m_loads++;
            exp_q.push_back({1'b1, 32'h0});
         end
      end else if (req_write) begin
         m_stores++;
         for (int b = 0; b < 4; b++)
            if (req_be[b])
               ref_mem[w][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
         m_loads++;
         exp_q.push_back({1'b0, ref_mem[w]});
      end
   endtask

   // Called at a negedge with inputs for the next posedge already set.
   task automatic tick();
      logic [32:0] e;
      if (req_valid && req_ready)
         accept();
      if (rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_extra: got err=%0b data=%h, required no response",
                     rsp_err, rsp_rdata);
         end else begin
            e = exp_q.pop_front();
            if ({rsp_err, rsp_rdata} !== e) begin
               errors++;
               $display("FAIL rsp_order: got err=%0b data=%h, required err=%0b data=%h",
                        rsp_err, rsp_rdata, e[32], e[31:0]);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      bit f;
      int n;
      n = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      do begin
         f = req_ready;
         tick();
         n++;
      end while (!f && n < 50);
      req_valid = 1'b0;
      checks++;
      if (!f) begin
         errors++;
         $display("FAIL issue_timeout: addr=%h not accepted, got ready=0, required 1", a);
      end
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("FAIL rsp_timeout: got rsp_valid=0, required 1");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain: got %0d pending, rsp_valid=%0b, required 0 and 0",
                  exp_q.size(), rsp_valid);
      end
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
          rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%0b valid=%0b data=%h err=%0b, required 0 0 0 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      exp_q.delete();
      m_loads = 0;
      m_stores = 0;
      m_errs = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %0b, required 1", req_ready);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      do_reset();
      rsp_ready = 1'b1;
   endtask

   task automatic test_latency();
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h10;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL lat_ready: got %0b, required 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_early: got rsp_valid=%0b one cycle after fire, required 0", rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL lat_data: got valid=%0b data=%h err=%0b, required 1 deadbeef 0",
                  rsp_valid, rsp_rdata, rsp_err);
      end
      tick();
   endtask

   task automatic test_byte_enable();
      issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
      issue(1'b1, 32'h20, 32'h11223344, 4'b0101);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      wait_rsp();
      checks++;
      if (rsp_rdata !== 32'hFF22FF44 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL byte_enable: got data=%h err=%0b, required ff22ff44 0",
                  rsp_rdata, rsp_err);
      end
      tick();
   endtask

   task automatic test_errors();
      logic [31:0] bad [2];
      bad[0] = 32'h13;
      bad[1] = 32'h1000;
      issue(1'b1, 32'h0, 32'hA5A50001, 4'hF);
      for (int i = 0; i < 2; i++) begin
         issue(1'b0, bad[i], 32'h0, 4'h0);
         wait_rsp();
         checks++;
         if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_load: addr=%h got err=%0b data=%h, required 1 00000000",
                     bad[i], rsp_err, rsp_rdata);
         end
         tick();
      end
      issue(1'b1, 32'h1002, 32'h0, 4'hF);
      issue(1'b1, 32'h1000, 32'h0, 4'hF);
      issue(1'b0, 32'h0, 32'h0, 4'h0);
      wait_rsp();
      checks++;
      if (rsp_rdata !== 32'hA5A50001 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL err_store_dropped: got data=%h err=%0b, required a5a50001 0",
                  rsp_rdata, rsp_err);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] al [3];
      logic [31:0] hold_d;
      logic        hold_e;
      int fires;
      al[0] = 32'h0;
      al[1] = 32'h10;
      al[2] = 32'h20;
      fires = 0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      for (int i = 0; i < 12; i++) begin
         req_addr = al[i % 3];
         if (req_ready)
            fires++;
         tick();
      end
      req_valid = 1'b0;
      checks++;
      if (fires != FIFO_D || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL credit_limit: got fires=%0d ready=%0b, required %0d 0",
                  fires, req_ready, FIFO_D);
      end
      hold_d = rsp_rdata;
      hold_e = rsp_err;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== hold_d || rsp_err !== hold_e) begin
         errors++;
         $display("FAIL rsp_stable: got valid=%0b data=%h, required 1 %h",
                  rsp_valid, rsp_rdata, hold_d);
      end
      drain();
   endtask

   task automatic test_store_then_load();
      issue(1'b1, 32'h40, 32'hCAFE0040, 4'hF);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h40;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL raw_ready: got %0b, required 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      wait_rsp();
      checks++;
      if (rsp_rdata !== 32'hCAFE0040) begin
         errors++;
         $display("FAIL raw_data: got %h, required cafe0040", rsp_rdata);
      end
      tick();
   endtask

   task automatic test_reset_inflight();
      int seen;
      drain();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h40;
      tick();
      req_addr  = 32'h10;
      tick();
      req_valid = 1'b0;
      do_reset();
      rsp_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid)
            seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL stale_rsp: got %0d responses after reset, required 0", seen);
      end
      issue(1'b0, 32'h40, 32'h0, 4'h0);
      wait_rsp();
      checks++;
      if (rsp_rdata !== 32'hCAFE0040) begin
         errors++;
         $display("FAIL ram_kept: got %h, required cafe0040", rsp_rdata);
      end
      tick();
   endtask

`ifdef DMEM_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      do_reset();
      rsp_ready = 1'b1;
      issue(1'b0, 32'h0, 32'h0, 4'h0);
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      issue(1'b1, 32'h50, 32'h1, 4'hF);
      issue(1'b1, 32'h54, 32'h2, 4'hF);
      issue(1'b1, 32'h51, 32'h3, 4'hF);
      drain();
      checks++;
      if (stat_loads !== 32'd3 || stat_stores !== 32'd2 || stat_errs !== 32'd1) begin
         errors++;
         $display("FAIL stats_fixed: got %0d/%0d/%0d, required 3/2/1",
                  stat_loads, stat_stores, stat_errs);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] hold_d;
      logic        hold_e;
      bit          stalled;
      int          r;
      for (int k = 0; k < 16; k++)
         issue(1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF);
      stalled = 1'b0;
      hold_d = '0;
      hold_e = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (stalled) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== hold_d || rsp_err !== hold_e) begin
               errors++;
               $display("FAIL rand_stable: cycle %0d got valid=%0b data=%h, required 1 %h",
                        c, rsp_valid, rsp_rdata, hold_d);
            end
         end
         r = $urandom_range(0, 9);
         req_valid = 1'($urandom_range(0, 1));
         req_write = 1'($urandom_range(0, 1));
         req_wdata = $urandom;
         req_be    = 4'($urandom_range(0, 15));
         req_addr  = 32'h100 + 32'(4 * $urandom_range(0, 15));
         if (r == 0)
            req_addr = req_addr + 32'($urandom_range(1, 3));
         else if (r == 1)
            req_addr = req_addr + 32'h4000_0000;
         rsp_ready = ($urandom_range(0, 3) != 0);
         stalled = rsp_valid && !rsp_ready;
         hold_d = rsp_rdata;
         hold_e = rsp_err;
         tick();
      end
      drain();
`ifdef DMEM_STATS_EN
      checks++;
      if (stat_loads !== 32'(m_loads) || stat_stores !== 32'(m_stores) ||
          stat_errs !== 32'(m_errs)) begin
         errors++;
         $display("FAIL stats_random: got %0d/%0d/%0d, required %0d/%0d/%0d",
                  stat_loads, stat_stores, stat_errs, m_loads, m_stores, m_errs);
      end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_latency();
      test_byte_enable();
      test_errors();
      test_back_to_back();
      test_store_then_load();
      test_reset_inflight();
`ifdef DMEM_STATS_EN
      test_stats();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
